// File: rtl/countdown_timer_if.sv
// rtl/countdown_timer_if.sv - command/status bundle between timer controller and display/alarm logic
//
// Signals:
//   cmd_load, load_bcd   load request and {min_tens, min_ones, sec_tens, sec_ones} BCD value
//   cmd_start            start / resume pulse
//   cmd_pause            pause pulse
//   cmd_clear            clear-to-idle pulse
//   time_bcd             current mm:ss count, same digit order as load_bcd
//   state                0 IDLE, 1 RUN, 2 PAUSE, 3 DONE
//   running              high while state is RUN
//   tick_1hz             one-cycle pulse per decrement
//   expired              one-cycle pulse on RUN->DONE
//   alarm                level, high while DONE
// master: the command issuer (drives cmd_*, observes status)
// slave:  the timer controller
interface countdown_timer_if;
    logic        cmd_load;
    logic [15:0] load_bcd;
    logic        cmd_start;
    logic        cmd_pause;
    logic        cmd_clear;
    logic [15:0] time_bcd;
    logic [1:0]  state;
    logic        running;
    logic        tick_1hz;
    logic        expired;
    logic        alarm;

    modport master (
        output cmd_load, load_bcd, cmd_start, cmd_pause, cmd_clear,
        input  time_bcd, state, running, tick_1hz, expired, alarm
    );

    modport slave (
        input  cmd_load, load_bcd, cmd_start, cmd_pause, cmd_clear,
        output time_bcd, state, running, tick_1hz, expired, alarm
    );
endinterface

// File: rtl/countdown_timer_ctrl.sv
// rtl/countdown_timer_ctrl.sv - mm:ss BCD countdown timer with prescaler and start/pause/clear FSM
//
// Parameters:
//   CLK_HZ    board clock frequency (informational)
//   TICK_DIV  clock cycles per one-second count step (>= 2)
// Ports:
//   clk_in    system clock, rising edge
//   reset     asynchronous active-high reset
//   tmr       countdown_timer_if.slave: commands in, time/state/pulses out
module countdown_timer_ctrl #(
    parameter int CLK_HZ   = 50000000,
    parameter int TICK_DIV = 50000000
) (
    input  logic               clk_in,
    input  logic               reset,
    countdown_timer_if.slave   tmr
);
    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    if (TICK_DIV < 2 || CLK_HZ < 1) begin : g_bad_param
        $error("countdown_timer_ctrl: TICK_DIV must be >= 2 and CLK_HZ positive");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t        state_q;
    logic [15:0]   time_q;
    logic [PW-1:0] pre_q;
    logic          running_q;
    logic          tick_q;
    logic          expired_q;
    logic          alarm_q;

    // Clamp each loaded digit into its legal BCD range.
    function automatic logic [15:0] sanitize(input logic [15:0] b);
        logic [3:0] mt, mo, st, so;
        mt = (b[15:12] > 4'd9) ? 4'd9 : b[15:12];
        mo = (b[11:8]  > 4'd9) ? 4'd9 : b[11:8];
        st = (b[7:4]   > 4'd5) ? 4'd5 : b[7:4];
        so = (b[3:0]   > 4'd9) ? 4'd9 : b[3:0];
        return {mt, mo, st, so};
    endfunction

    // One-second decrement with a borrow chain across the mixed 10/6/10/10 radix.
    function automatic logic [15:0] bcd_dec(input logic [15:0] b);
        logic [15:0] r;
        r = b;
        if (b[3:0] != 4'd0) begin
            r[3:0] = b[3:0] - 4'd1;
        end else begin
            r[3:0] = 4'd9;
            if (b[7:4] != 4'd0) begin
                r[7:4] = b[7:4] - 4'd1;
            end else begin
                r[7:4] = 4'd5;
                if (b[11:8] != 4'd0) begin
                    r[11:8] = b[11:8] - 4'd1;
                end else begin
                    r[11:8]  = 4'd9;
                    r[15:12] = b[15:12] - 4'd1;
                end
            end
        end
        return r;
    endfunction

    logic        time_zero;
    logic        do_clear;
    logic        do_load;
    logic        do_start;
    logic        do_pause;
    logic        do_step;
    logic [15:0] dec_val;
    logic        dec_zero;
    logic [15:0] load_val;

    // Only the highest-priority asserted pulse is considered; if that one is
    // not legal in the current state, nothing is accepted and counting goes on.
    always_comb begin
        time_zero = (time_q == 16'h0000);
        do_clear  = tmr.cmd_clear;
        do_load   = !tmr.cmd_clear && tmr.cmd_load;
        do_start  = !tmr.cmd_clear && !tmr.cmd_load && tmr.cmd_start
                    && (state_q != S_RUN) && !time_zero;
        do_pause  = !tmr.cmd_clear && !tmr.cmd_load && !tmr.cmd_start
                    && tmr.cmd_pause && (state_q == S_RUN);
        do_step   = (state_q == S_RUN) && (pre_q == PRE_LAST) && !time_zero
                    && !(do_clear || do_load || do_start || do_pause);
        dec_val   = bcd_dec(time_q);
        dec_zero  = (dec_val == 16'h0000);
        load_val  = sanitize(tmr.load_bcd);
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            time_q    <= 16'h0000;
            pre_q     <= '0;
            running_q <= 1'b0;
            tick_q    <= 1'b0;
            expired_q <= 1'b0;
            alarm_q   <= 1'b0;
        end else begin
            tick_q    <= do_step;
            expired_q <= do_step && dec_zero;
            if (do_clear) begin
                time_q    <= 16'h0000;
                state_q   <= S_IDLE;
                pre_q     <= '0;
                running_q <= 1'b0;
                alarm_q   <= 1'b0;
            end else if (do_load) begin
                time_q    <= load_val;
                state_q   <= S_IDLE;
                pre_q     <= '0;
                running_q <= 1'b0;
                alarm_q   <= 1'b0;
            end else if (do_start) begin
                state_q   <= S_RUN;
                running_q <= 1'b1;
                alarm_q   <= 1'b0;
                // Resume from PAUSE keeps the partial second already counted.
                if (state_q != S_PAUSE) begin
                    pre_q <= '0;
                end
            end else if (do_pause) begin
                state_q   <= S_PAUSE;
                running_q <= 1'b0;
            end else if (state_q == S_RUN) begin
                if (pre_q == PRE_LAST) begin
                    pre_q <= '0;
                    if (do_step) begin
                        time_q <= dec_val;
                        if (dec_zero) begin
                            state_q   <= S_DONE;
                            running_q <= 1'b0;
                            alarm_q   <= 1'b1;
                        end
                    end
                end else begin
                    pre_q <= pre_q + 1'b1;
                end
            end
        end
    end

    assign tmr.time_bcd = time_q;
    assign tmr.state    = state_q;
    assign tmr.running  = running_q;
    assign tmr.tick_1hz = tick_q;
    assign tmr.expired  = expired_q;
    assign tmr.alarm    = alarm_q;
endmodule

// File: tb/tb_countdown_timer_ctrl.sv
// tb/tb_countdown_timer_ctrl.sv - self-checking bench for countdown_timer_ctrl
module tb_countdown_timer_ctrl;
    localparam int TD = 4;

    logic clk_in = 1'b0;
    logic reset  = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    countdown_timer_if bus();

    countdown_timer_ctrl #(.CLK_HZ(50000000), .TICK_DIV(TD)) dut (
        .clk_in (clk_in),
        .reset  (reset),
        .tmr    (bus.slave)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: count kept as plain seconds, converted to BCD only for comparison.
    int m_secs = 0;
    int m_st   = 0;
    int m_pre  = 0;
    bit m_tick = 0;
    bit m_exp  = 0;

    function automatic int digit_clamp(input int d, input int lim);
        return (d > lim) ? lim : d;
    endfunction

    function automatic int load_secs(input logic [15:0] b);
        int mm, ss;
        mm = digit_clamp(int'(b[15:12]), 9) * 10 + digit_clamp(int'(b[11:8]), 9);
        ss = digit_clamp(int'(b[7:4]), 5) * 10 + digit_clamp(int'(b[3:0]), 9);
        return mm * 60 + ss;
    endfunction

    function automatic logic [15:0] secs_bcd(input int s);
        int mm, ss;
        mm = s / 60;
        ss = s % 60;
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    always @(posedge clk_in or posedge reset) begin
        bit took;
        if (reset) begin
            m_secs = 0; m_st = 0; m_pre = 0; m_tick = 0; m_exp = 0;
        end else begin
            m_tick = 0;
            m_exp  = 0;
            took   = 0;
            if (bus.cmd_clear) begin
                m_secs = 0; m_st = 0; m_pre = 0; took = 1;
            end else if (bus.cmd_load) begin
                m_secs = load_secs(bus.load_bcd); m_st = 0; m_pre = 0; took = 1;
            end else if (bus.cmd_start) begin
                if (m_st != 1 && m_secs != 0) begin
                    if (m_st != 2) m_pre = 0;
                    m_st = 1;
                    took = 1;
                end
            end else if (bus.cmd_pause) begin
                if (m_st == 1) begin
                    m_st = 2;
                    took = 1;
                end
            end
            if (!took && m_st == 1) begin
                if (m_pre == TD - 1) begin
                    m_pre  = 0;
                    m_secs = m_secs - 1;
                    m_tick = 1;
                    if (m_secs == 0) begin
                        m_st  = 3;
                        m_exp = 1;
                    end
                end else begin
                    m_pre = m_pre + 1;
                end
            end
        end
    end

    always @(negedge clk_in) begin
        check("cyc_time",    32'(bus.time_bcd), 32'(secs_bcd(m_secs)));
        check("cyc_state",   32'(bus.state),    32'(m_st));
        check("cyc_running", 32'(bus.running),  32'(m_st == 1));
        check("cyc_tick",    32'(bus.tick_1hz), 32'(m_tick));
        check("cyc_expired", 32'(bus.expired),  32'(m_exp));
        check("cyc_alarm",   32'(bus.alarm),    32'(m_st == 3));
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic pulse(input bit c, input bit l, input bit s, input bit p, input logic [15:0] v);
        bus.cmd_clear = c;
        bus.cmd_load  = l;
        bus.cmd_start = s;
        bus.cmd_pause = p;
        bus.load_bcd  = v;
        @(posedge clk_in);
        #1;
        bus.cmd_clear = 1'b0;
        bus.cmd_load  = 1'b0;
        bus.cmd_start = 1'b0;
        bus.cmd_pause = 1'b0;
    endtask

    initial begin
        bus.cmd_clear = 1'b0;
        bus.cmd_load  = 1'b0;
        bus.cmd_start = 1'b0;
        bus.cmd_pause = 1'b0;
        bus.load_bcd  = 16'h0000;
        step(2);
        reset = 1'b0;
        check("rst_time",    32'(bus.time_bcd), 32'h0000);
        check("rst_state",   32'(bus.state),    32'd0);
        check("rst_running", 32'(bus.running),  32'd0);
        check("rst_alarm",   32'(bus.alarm),    32'd0);

        // Count 00:03 down to expiry.
        pulse(0, 1, 0, 0, 16'h0003);
        pulse(0, 0, 1, 0, 16'h0000);
        step(TD);
        check("c3_t4",      32'(bus.time_bcd), 32'h0002);
        check("c3_tick4",   32'(bus.tick_1hz), 32'd1);
        step(TD);
        check("c3_t8",      32'(bus.time_bcd), 32'h0001);
        step(TD);
        check("c3_t12",     32'(bus.time_bcd), 32'h0000);
        check("c3_exp12",   32'(bus.expired),  32'd1);
        check("c3_state12", 32'(bus.state),    32'd3);
        step(1);
        check("c3_exp13",   32'(bus.expired),  32'd0);
        check("c3_alarm13", 32'(bus.alarm),    32'd1);
        check("c3_state13", 32'(bus.state),    32'd3);

        // Borrow chains.
        pulse(0, 1, 0, 0, 16'h1000);
        pulse(0, 0, 1, 0, 16'h0000);
        step(TD);
        check("borrow_1000", 32'(bus.time_bcd), 32'h0959);
        pulse(0, 1, 0, 0, 16'h0100);
        pulse(0, 0, 1, 0, 16'h0000);
        step(TD);
        check("borrow_0100", 32'(bus.time_bcd), 32'h0059);

        // Pause with prescaler at 2, hold, resume: next decrement two edges later.
        pulse(0, 1, 0, 0, 16'h0005);
        pulse(0, 0, 1, 0, 16'h0000);
        step(2);
        pulse(0, 0, 0, 1, 16'h0000);
        step(10);
        check("pause_time",  32'(bus.time_bcd), 32'h0005);
        check("pause_state", 32'(bus.state),    32'd2);
        pulse(0, 0, 1, 0, 16'h0000);
        check("resume_state", 32'(bus.state),   32'd1);
        step(1);
        check("resume_r1",   32'(bus.time_bcd), 32'h0005);
        step(1);
        check("resume_r2",   32'(bus.time_bcd), 32'h0004);
        check("resume_tick", 32'(bus.tick_1hz), 32'd1);

        // Priority: clear beats load and start; start at zero ignored.
        pulse(1, 1, 1, 0, 16'h0030);
        check("prio_time",  32'(bus.time_bcd), 32'h0000);
        check("prio_state", 32'(bus.state),    32'd0);
        pulse(0, 0, 1, 0, 16'h0000);
        check("start_zero", 32'(bus.state),    32'd0);

        // Digit sanitising.
        pulse(0, 1, 0, 0, 16'h7A6C);
        check("sanitize", 32'(bus.time_bcd), 32'h7959);

        // DONE handling: start at zero stays DONE, reload and start runs again.
        pulse(0, 1, 0, 0, 16'h0002);
        pulse(0, 0, 1, 0, 16'h0000);
        step(2 * TD);
        check("done_state", 32'(bus.state), 32'd3);
        check("done_alarm", 32'(bus.alarm), 32'd1);
        pulse(0, 0, 1, 0, 16'h0000);
        check("done_start0", 32'(bus.state), 32'd3);
        pulse(0, 1, 0, 0, 16'h0002);
        check("reload_alarm", 32'(bus.alarm), 32'd0);
        pulse(0, 0, 1, 0, 16'h0000);
        check("rerun_state",   32'(bus.state),   32'd1);
        check("rerun_running", 32'(bus.running), 32'd1);

        // Asynchronous reset mid-run.
        pulse(0, 1, 0, 0, 16'h0010);
        pulse(0, 0, 1, 0, 16'h0000);
        step(5);
        #2;
        reset = 1'b1;
        #1;
        check("arst_time",    32'(bus.time_bcd), 32'h0000);
        check("arst_state",   32'(bus.state),    32'd0);
        check("arst_running", 32'(bus.running),  32'd0);
        check("arst_tick",    32'(bus.tick_1hz), 32'd0);
        check("arst_alarm",   32'(bus.alarm),    32'd0);
        #2;
        reset = 1'b0;
        step(2 * TD);
        check("post_rst_time",  32'(bus.time_bcd), 32'h0000);
        check("post_rst_state", 32'(bus.state),    32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
